// File: rtl/disp_pkg.sv
// Shared types, segment codes and helpers for the BCD scanning display.
// Segment codes are active-low, bit 6 = segment a down to bit 0 = segment g.
package disp_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SHIFT  = 2'd1,
    ST_COMMIT = 2'd2
  } conv_state_t;

  localparam logic [6:0] SEG_0     = 7'b0000001;
  localparam logic [6:0] SEG_1     = 7'b1001111;
  localparam logic [6:0] SEG_2     = 7'b0010010;
  localparam logic [6:0] SEG_3     = 7'b0000110;
  localparam logic [6:0] SEG_4     = 7'b1001100;
  localparam logic [6:0] SEG_5     = 7'b0100100;
  localparam logic [6:0] SEG_6     = 7'b0100000;
  localparam logic [6:0] SEG_7     = 7'b0001111;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0000100;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_DASH  = 7'b1111110;

  function automatic logic [6:0] seg_of(input logic [3:0] d);
    case (d)
      4'd0:    return SEG_0;
      4'd1:    return SEG_1;
      4'd2:    return SEG_2;
      4'd3:    return SEG_3;
      4'd4:    return SEG_4;
      4'd5:    return SEG_5;
      4'd6:    return SEG_6;
      4'd7:    return SEG_7;
      4'd8:    return SEG_8;
      4'd9:    return SEG_9;
      default: return SEG_BLANK;
    endcase
  endfunction

  // Elaboration-time 10^n, wide enough for any practical digit count.
  function automatic logic [63:0] pow10(input int n);
    logic [63:0] r;
    r = 64'd1;
    for (int i = 0; i < n; i++) r = r * 64'd10;
    return r;
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble converter holding the committed display digits.
// load is accepted only in IDLE; the state output shows IDLE/SHIFT/COMMIT.
module bin2bcd_seq
  import disp_pkg::*;
#(
  parameter int DATA_W  = 16,
  parameter int BCD_DIG = 5
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 load,
  input  logic [DATA_W-1:0]    data,
  output conv_state_t          state,
  output logic                 ovf,
  output logic [4*BCD_DIG-1:0] bcd
);

  localparam int BW = 4 * BCD_DIG;
  localparam int CW = $clog2(DATA_W + 1);
  localparam logic [63:0] LIMIT = pow10(BCD_DIG);

  conv_state_t       state_q, state_d;
  logic [DATA_W-1:0] sr_q;
  logic [BW-1:0]     work_q, work_adj, disp_q;
  logic [CW-1:0]     cnt_q;
  logic              ovf_next_q, ovf_q;
  logic [3:0]        nib;

  always_comb begin
    work_adj = work_q;
    nib      = '0;
    for (int i = 0; i < BCD_DIG; i++) begin
      nib = work_q[4*i +: 4];
      work_adj[4*i +: 4] = (nib >= 4'd5) ? nib + 4'd3 : nib;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (load) state_d = ST_SHIFT;
      ST_SHIFT:  if (cnt_q == CW'(DATA_W - 1)) state_d = ST_COMMIT;
      ST_COMMIT: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Top digits beyond BCD_DIG fall off; ovf_next covers that case.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sr_q       <= '0;
      work_q     <= '0;
      cnt_q      <= '0;
      ovf_next_q <= 1'b0;
      disp_q     <= '0;
      ovf_q      <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: if (load) begin
          sr_q       <= data;
          work_q     <= '0;
          cnt_q      <= '0;
          ovf_next_q <= (64'(data) >= LIMIT);
        end
        ST_SHIFT: begin
          work_q <= {work_adj[BW-2:0], sr_q[DATA_W-1]};
          sr_q   <= sr_q << 1;
          cnt_q  <= cnt_q + 1'b1;
        end
        ST_COMMIT: begin
          disp_q <= work_q;
          ovf_q  <= ovf_next_q;
        end
        default: ;
      endcase
    end
  end

  assign state = state_q;
  assign ovf   = ovf_q;
  assign bcd   = disp_q;

endmodule

// File: rtl/disp_bcd_scan.sv
// Binary-to-BCD multiplexed 7-segment driver with program/mode fields.
// Handshake: load is taken only while busy=0; busy covers SHIFT+COMMIT, done pulses in COMMIT.
module disp_bcd_scan
  import disp_pkg::*;
#(
  parameter int DATA_W   = 16,
  parameter int BCD_DIG  = 5,
  parameter int N_AN     = 8,
  parameter int SCAN_DIV = 100000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [DATA_W-1:0] data,
  input  logic [2:0]        prog,
  input  logic [1:0]        modulo,
  input  logic              blank_lz,
  input  logic [N_AN-1:0]   dp_mask,
  output logic              busy,
  output logic              done,
  output logic              ovf,
  output logic [N_AN-1:0]   an,
  output logic [7:0]        dec_ddp
);

  localparam int PW = $clog2(SCAN_DIV);
  localparam int IW = $clog2(N_AN);

  conv_state_t          conv_state;
  logic [4*BCD_DIG-1:0] disp_bcd;
  logic [PW-1:0]        presc_q;
  logic [IW-1:0]        idx_q;
  logic [3:0]           digit;
  logic                 upper_zero;
  logic [6:0]           seg_d;
  logic [N_AN-1:0]      an_q;
  logic [7:0]           ddp_q;

  bin2bcd_seq #(.DATA_W(DATA_W), .BCD_DIG(BCD_DIG)) u_conv (
    .clk   (clk),
    .rst   (rst),
    .load  (load),
    .data  (data),
    .state (conv_state),
    .ovf   (ovf),
    .bcd   (disp_bcd)
  );

  assign busy = (conv_state != ST_IDLE);
  assign done = (conv_state == ST_COMMIT);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc_q <= '0;
      idx_q   <= '0;
    end else if (presc_q == PW'(SCAN_DIV - 1)) begin
      presc_q <= '0;
      idx_q   <= (idx_q == IW'(N_AN - 1)) ? '0 : idx_q + 1'b1;
    end else begin
      presc_q <= presc_q + 1'b1;
    end
  end

  // upper_zero: this digit and every digit above it are zero.
  always_comb begin
    seg_d      = SEG_BLANK;
    digit      = '0;
    upper_zero = 1'b1;
    for (int j = 0; j < BCD_DIG; j++) begin
      if (int'(idx_q) == j) digit = disp_bcd[4*j +: 4];
      if (j >= int'(idx_q) && disp_bcd[4*j +: 4] != 4'd0) upper_zero = 1'b0;
    end
    if (int'(idx_q) < BCD_DIG) begin
      if (ovf)                                   seg_d = SEG_DASH;
      else if (blank_lz && upper_zero && idx_q != '0) seg_d = SEG_BLANK;
      else                                       seg_d = seg_of(digit);
    end else if (int'(idx_q) == N_AN - 3) begin
      seg_d = seg_of({2'b00, modulo});
    end else if (int'(idx_q) == N_AN - 1) begin
      seg_d = seg_of({1'b0, prog});
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      an_q  <= '1;
      ddp_q <= '1;
    end else begin
      an_q  <= ~(N_AN'(1) << idx_q);
      ddp_q <= {seg_d, ~dp_mask[idx_q]};
    end
  end

  assign an      = an_q;
  assign dec_ddp = ddp_q;

endmodule

// File: tb/tb_disp_bcd_scan.sv
// Bench for disp_bcd_scan: two instances (5 and 4 digits) share stimulus
// and are compared against a decimal-arithmetic model of the display.
module tb_disp_bcd_scan;

  logic        clk = 1'b0;
  logic        rst;
  logic        load;
  logic [15:0] data;
  logic [2:0]  prog;
  logic [1:0]  modulo;
  logic        blank_lz;
  logic [7:0]  dp_mask;
  logic        busy_5, done_5, ovf_5, busy_4, done_4, ovf_4;
  logic [7:0]  an_5, ddp_5, an_4, ddp_4;

  int total  = 0;
  int passed = 0;
  int model_val = 0;

  logic [6:0] seg_tbl [10] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
                               7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
                               7'b0000000, 7'b0000100};

  always #5 clk = ~clk;

  disp_bcd_scan #(.DATA_W(16), .BCD_DIG(5), .N_AN(8), .SCAN_DIV(4)) dut (
    .clk(clk), .rst(rst), .load(load), .data(data), .prog(prog), .modulo(modulo),
    .blank_lz(blank_lz), .dp_mask(dp_mask), .busy(busy_5), .done(done_5),
    .ovf(ovf_5), .an(an_5), .dec_ddp(ddp_5)
  );

  disp_bcd_scan #(.DATA_W(16), .BCD_DIG(4), .N_AN(8), .SCAN_DIV(4)) dut4 (
    .clk(clk), .rst(rst), .load(load), .data(data), .prog(prog), .modulo(modulo),
    .blank_lz(blank_lz), .dp_mask(dp_mask), .busy(busy_4), .done(done_4),
    .ovf(ovf_4), .an(an_4), .dec_ddp(ddp_4)
  );

  function automatic int p10(input int n);
    int r = 1;
    for (int i = 0; i < n; i++) r = r * 10;
    return r;
  endfunction

  // Expected cathodes for anode k of a display with bd number digits.
  function automatic logic [7:0] exp_ddp(input int bd, input int k);
    logic [6:0] s;
    s = 7'b1111111;
    if (k < bd) begin
      if (model_val >= p10(bd))                          s = 7'b1111110;
      else if (blank_lz && k > 0 && model_val < p10(k)) s = 7'b1111111;
      else                                               s = seg_tbl[(model_val / p10(k)) % 10];
    end else if (k == 5) begin
      s = seg_tbl[modulo];
    end else if (k == 7) begin
      s = seg_tbl[prog];
    end
    return {s, ~dp_mask[k]};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic read_anode(input int k);
    logic [7:0] want;
    int n;
    want = ~(8'd1 << k);
    n = 0;
    while (an_5 !== want && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk($sformatf("an5_reach_%0d", k), an_5, want);
    chk($sformatf("ddp5_anode_%0d", k), ddp_5, exp_ddp(5, k));
    chk($sformatf("an4_reach_%0d", k), an_4, want);
    chk($sformatf("ddp4_anode_%0d", k), ddp_4, exp_ddp(4, k));
  endtask

  task automatic check_frame();
    repeat (2) @(negedge clk);
    for (int k = 0; k < 8; k++) read_anode(k);
  endtask

  task automatic do_load(input int v);
    int bc, dc, n;
    @(negedge clk);
    load = 1'b1;
    data = 16'(v);
    @(negedge clk);
    load = 1'b0;
    bc = 0; dc = 0; n = 0;
    while (busy_5 && n < 60) begin
      bc++;
      if (done_5) dc++;
      @(negedge clk);
      n++;
    end
    model_val = v;
    chk("busy_cycles", bc, 17);
    chk("done_pulses", dc, 1);
    chk("busy4_low", busy_4, 1'b0);
    chk("ovf5", ovf_5, (v >= 100000));
    chk("ovf4", ovf_4, (v >= 10000));
  endtask

  initial begin
    logic [7:0] prev;
    int run, dc, n;
    bit seen;

    rst = 1'b1; load = 1'b0; data = '0; prog = '0; modulo = '0;
    blank_lz = 1'b0; dp_mask = '0;
    repeat (3) @(negedge clk);
    chk("rst_an", an_5, 8'hFF);
    chk("rst_ddp", ddp_5, 8'hFF);
    chk("rst_busy", busy_5, 1'b0);
    chk("rst_done", done_5, 1'b0);
    chk("rst_ovf", ovf_5, 1'b0);
    chk("rst_an4", an_4, 8'hFF);
    rst = 1'b0;
    @(negedge clk);
    chk("first_an", an_5, 8'hFE);
    chk("first_digit", ddp_5, {7'b0000001, 1'b1});

    // Scan walk: single low bit, rotate left each change, 4 cycles per slot.
    prev = an_5; run = 1; seen = 0;
    for (int i = 0; i < 70; i++) begin
      @(negedge clk);
      chk("an_onehot", $countones(~an_5), 1);
      if (an_5 != prev) begin
        chk("an_rotate", an_5, {prev[6:0], prev[7]});
        if (seen) chk("slot_len", run, 4);
        seen = 1; run = 1; prev = an_5;
      end else begin
        run++;
      end
    end

    do_load(1234);
    check_frame();
    blank_lz = 1'b1;
    check_frame();

    do_load(9999);
    check_frame();
    do_load(10000);
    check_frame();
    do_load(0);
    check_frame();
    do_load(65535);
    check_frame();

    prog = 3'd5; modulo = 2'd2; dp_mask = 8'h04; blank_lz = 1'b0;
    do_load(42);
    check_frame();

    repeat (5) begin
      blank_lz = 1'($urandom_range(0, 1));
      dp_mask  = 8'($urandom);
      prog     = 3'($urandom_range(0, 7));
      modulo   = 2'($urandom_range(0, 3));
      do_load($urandom_range(0, 65535));
      check_frame();
    end

    // Second load three cycles after the first must be ignored.
    @(negedge clk);
    load = 1'b1; data = 16'd4321;
    @(negedge clk);
    load = 1'b0;
    dc = 0; n = 0;
    repeat (2) begin
      if (done_5) dc++;
      @(negedge clk);
    end
    load = 1'b1; data = 16'd777;
    while ((busy_5 || load) && n < 60) begin
      if (done_5) dc++;
      @(negedge clk);
      load = 1'b0;
      n++;
    end
    repeat (20) begin
      if (done_5) dc++;
      @(negedge clk);
    end
    model_val = 4321;
    chk("dup_done_pulses", dc, 1);
    check_frame();

    // Reset in the middle of SHIFT, after an overflowing value is on dut4.
    do_load(50000);
    chk("pre_rst_ovf4", ovf_4, 1'b1);
    @(negedge clk);
    load = 1'b1; data = 16'd31337;
    @(negedge clk);
    load = 1'b0;
    repeat (7) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("midrst_an", an_5, 8'hFF);
    chk("midrst_busy", busy_5, 1'b0);
    chk("midrst_ddp", ddp_5, 8'hFF);
    chk("midrst_ovf4", ovf_4, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    model_val = 0;
    blank_lz = 1'b1;
    check_frame();
    chk("post_rst_ovf4", ovf_4, 1'b0);
    chk("post_rst_busy", busy_5, 1'b0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
